// File: rtl/xor_pkg.sv
// Shared definitions for the XOR checksum block: FSM state encoding and
// the helper that sizes the packet-length field from the maximum beat count.
package xor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/xor_word.sv
// WIDTH-bit bitwise XOR assembled from one 2-input XOR gate per bit.
// Shared by the accumulator update and each level of the parity tree.
module xor_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor u_xor (y[i], a[i], b[i]);
  end

endmodule

// File: rtl/xor_checksum.sv
// Streaming XOR reducer: takes a packet length, XORs that many accepted words
// together and offers the checksum plus its parity on a valid/ready port.
module xor_checksum
  import xor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
  localparam int               PLEVELS   = $clog2(WIDTH);
  localparam int               PW        = 1 << PLEVELS;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] acc_xor;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_nxt;
  logic [LEN_W-1:0] len_clamped;
  logic             parity;

  xor_word #(.WIDTH(WIDTH)) u_acc_xor (
    .a (acc),
    .b (in_data),
    .y (acc_xor)
  );

  // Parity is a balanced tree: each level folds the upper half of the
  // previous level onto the lower half, with the leaf level zero-padded
  // up to a power of two.
  for (genvar l = 0; l <= PLEVELS; l++) begin : g_par
    logic [(PW >> l)-1:0] vec;
    if (l == 0) begin : g_leaf
      always_comb begin
        vec              = '0;
        vec[WIDTH-1:0]   = acc;
      end
    end else begin : g_node
      xor_word #(.WIDTH(PW >> l)) u_node (
        .a (g_par[l-1].vec[(PW >> l)-1:0]),
        .b (g_par[l-1].vec[(PW >> (l-1))-1:(PW >> l)]),
        .y (vec)
      );
    end
  end

  assign parity = g_par[PLEVELS].vec[0];

  always_comb begin
    len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
    end
  end

  // Outputs decode from state and the accumulator only; the sole input
  // dependence is the handshake deciding whether a word is folded in.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    count_nxt  = count;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_sum    = '0;
    out_parity = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          acc_nxt = '0;
          if (len == '0) begin
            state_nxt = DONE;
          end else begin
            count_nxt = len_clamped;
            state_nxt = ACCUM;
          end
        end
      end

      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt   = acc_xor;
          count_nxt = count - ONE_L;
          if (count == ONE_L) begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        out_valid  = 1'b1;
        out_sum    = acc;
        out_parity = parity;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_xor_checksum.sv
// Self-checking bench for xor_checksum: directed packets with literal
// expectations plus a long randomized run checked against a packet-level model.
module tb_xor_checksum;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_parity;
  logic             out_ready;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model state: which phase the packet is in, beats still owed, words taken.
  bit         m_accum = 1'b0;
  bit         m_done  = 1'b0;
  int         m_left  = 0;
  logic [7:0] m_words[$];

  logic [7:0] beats[$];

  xor_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .out_parity (out_parity),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] modelSum();
    logic [7:0] s = 8'h00;
    foreach (m_words[i]) s = s ^ m_words[i];
    return s;
  endfunction

  function automatic logic modelParity(input logic [7:0] s);
    return ($countones(s) % 2) == 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packet-level reference: advances on each clock edge from the inputs alone.
  always @(posedge clk) begin
    int n;
    if (rst) begin
      m_accum = 1'b0;
      m_done  = 1'b0;
      m_words.delete();
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_accum) begin
      if (in_valid) begin
        m_words.push_back(in_data);
        m_left--;
        if (m_left == 0) begin
          m_accum = 1'b0;
          m_done  = 1'b1;
        end
      end
    end else if (start) begin
      m_words.delete();
      n = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
      if (n == 0) begin
        m_done = 1'b1;
      end else begin
        m_accum = 1'b1;
        m_left  = n;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc in_ready", 32'(in_ready), 32'(m_accum));
      checkOutput("cyc out_valid", 32'(out_valid), 32'(m_done));
      checkOutput("cyc busy", 32'(busy), 32'(m_accum || m_done));
      if (m_done) begin
        checkOutput("cyc out_sum", 32'(out_sum), 32'(modelSum()));
        checkOutput("cyc out_parity", 32'(out_parity), 32'(modelParity(modelSum())));
      end
    end
  end

  task automatic applyStimulus(input int plen, input int gap);
    start = 1'b1;
    len   = LEN_W'(plen);
    tick();
    start = 1'b0;
    foreach (beats[i]) begin
      in_valid = 1'b1;
      in_data  = beats[i];
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (i != beats.size() - 1) repeat (gap) tick();
    end
  endtask

  task automatic waitResult(input string name, input logic [7:0] exp_sum, input logic exp_par,
                            input int exp_wait, input int hold);
    int w = 0;
    while (out_valid !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (out_valid !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s timeout: out_valid got 0, expected 1", name);
      return;
    end
    if (exp_wait >= 0) checkOutput({name, " latency"}, 32'(w), 32'(exp_wait));
    repeat (hold) begin
      checkOutput({name, " hold sum"}, 32'(out_sum), 32'(exp_sum));
      checkOutput({name, " hold parity"}, 32'(out_parity), 32'(exp_par));
      start = ~start;
      tick();
    end
    checkOutput({name, " sum"}, 32'(out_sum), 32'(exp_sum));
    checkOutput({name, " parity"}, 32'(out_parity), 32'(exp_par));
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    checkOutput({name, " valid drop"}, 32'(out_valid), 32'd0);
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_sum", 32'(out_sum), 32'd0);
    checkOutput("reset out_parity", 32'(out_parity), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);

    beats = '{8'h0F, 8'hF0, 8'hAA, 8'h55};
    applyStimulus(4, 0);
    waitResult("pkt4", 8'h00, 1'b0, 0, 0);

    beats = '{8'hA7};
    applyStimulus(1, 0);
    waitResult("pkt1", 8'hA7, 1'b1, 0, 0);

    beats.delete();
    applyStimulus(0, 0);
    waitResult("pkt0", 8'h00, 1'b0, 0, 0);

    beats = '{8'h01, 8'h02, 8'h04};
    applyStimulus(3, 2);
    waitResult("pkt3 gaps", 8'h07, 1'b1, 0, 5);

    beats.delete();
    repeat (17) beats.push_back(8'h01);
    applyStimulus(20, 0);
    checkOutput("clamp in_ready", 32'(in_ready), 32'd0);
    waitResult("clamp", 8'h00, 1'b0, -1, 0);

    beats = '{8'h11, 8'h22};
    applyStimulus(4, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort out_sum", 32'(out_sum), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd0);
    beats = '{8'h3C, 8'h0F};
    applyStimulus(2, 0);
    waitResult("after abort", 8'h33, 1'b0, 0, 0);

    repeat (3000) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 7) == 0);
      len       = LEN_W'($urandom_range(0, 31));
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
